// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, bit timing and the bridge state encoding.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int CLKS_PER_BIT = 10416;  // 100 MHz / 9600 baud

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } bridge_state_t;

  // Clock cycles one UART frame of the given bit count occupies on the line.
  function automatic int unsigned frame_clks(input int unsigned bits);
    return bits * CLKS_PER_BIT;
  endfunction

endpackage

// File: rtl/uart_rx_tx_bridge_if.sv
// Bundle of receiver-side, transmitter-side and status signals around the bridge.
// The bridge takes the slave view; the surrounding logic takes the master view.
interface uart_rx_tx_bridge_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rx_byte;
  logic              rx_dv;
  logic [DATA_W-1:0] tx_byte;
  logic              tx_dv;
  logic              tx_active;
  logic              tx_done;
  logic [CW-1:0]     fifo_count;
  logic              full;
  logic              empty;
  logic              overflow;

  modport master (
    output rx_byte, rx_dv, tx_active, tx_done,
    input  tx_byte, tx_dv, fifo_count, full, empty, overflow
  );

  modport slave (
    input  rx_byte, rx_dv, tx_active, tx_done,
    output tx_byte, tx_dv, fifo_count, full, empty, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data. A push into a full FIFO is
// dropped and flagged unless a pop frees the slot in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = UART_DATA_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CW-1:0]     count_next;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next occupancy, so full/empty can be registered alongside count.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage write; no reset needed, occupancy tracking guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy flags, read register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_tx_bridge.sv
// Buffers received bytes and feeds them to the transmitter one at a time,
// waiting for each stop bit to finish before loading the next byte.
// The FIFO's registered read data doubles as the tx_byte holding register:
// it only changes on a pop, so tx_byte stays stable until the next hand-off.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | wait for a stored byte and an idle transmitter, then pop
//   SEND      | tx_dv high for this single cycle
//   WAIT_DONE | transmitter busy; wait for its tx_done strobe
//   GAP       | one spare cycle so tx_active can fall before the next pop
module uart_rx_tx_bridge
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input logic               clk,
  input logic               rst,
  uart_rx_tx_bridge_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  bridge_state_t     state;
  bridge_state_t     state_next;
  logic              pop;
  logic              tx_dv_q;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_overflow;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.rx_dv),
    .din      (bus.rx_byte),
    .pop      (pop),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake sequencing and pop request.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.tx_active) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done) state_next = GAP;
      GAP:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Load strobe registered so it is glitch-free and high only while in SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_dv_q <= 1'b0;
    else     tx_dv_q <= (state_next == SEND);
  end

  assign bus.tx_byte    = fifo_dout;
  assign bus.tx_dv      = tx_dv_q;
  assign bus.fifo_count = fifo_count;
  assign bus.full       = fifo_full;
  assign bus.empty      = fifo_empty;
  assign bus.overflow   = fifo_overflow;

endmodule
